// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file and its pending-write scoreboard.
package regfile_pkg;
    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_ADDR_W = 5;
    localparam int unsigned REG_ZERO  = 0;

    typedef logic [RF_ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register count of in-flight producers, with sticky saturation/underflow
// diagnostics and read-port busy flags for decode stalling.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned NREAD    = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter int unsigned CNT_W    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       wa,
    input  logic                    iss_valid,
    input  logic [ADDR_W-1:0]       iss_dst,
    input  logic [NREAD*ADDR_W-1:0] ra,
    output logic [NREAD-1:0]        rd_busy,
    output logic                    sb_overflow,
    output logic                    sb_underflow
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt     [DEPTH];
    logic [CNT_W-1:0] w_cnt_nxt [DEPTH];
    logic [DEPTH-1:0] w_inc;
    logic [DEPTH-1:0] w_dec;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic             r_ovf;
    logic             r_unf;
    logic [NREAD-1:0] w_busy;

    always_comb begin
        w_inc     = '0;
        w_dec     = '0;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
            w_cnt_nxt[r] = r_cnt[r];
            // The hard-wired zero register is never tracked and never flags.
            if (!(ZERO_REG && (r == REG_ZERO))) begin
                w_inc[r] = iss_valid && (iss_dst == ADDR_W'(r));
                w_dec[r] = we && (wa == ADDR_W'(r)) && (r_cnt[r] != '0);
                if (we && (wa == ADDR_W'(r)) && (r_cnt[r] == '0)) begin
                    w_unf_set = 1'b1;
                end
                if (w_inc[r] && !w_dec[r]) begin
                    if (r_cnt[r] == CNT_MAX) begin
                        w_ovf_set = 1'b1;
                    end else begin
                        w_cnt_nxt[r] = r_cnt[r] + CNT_W'(1);
                    end
                end else if (w_dec[r] && !w_inc[r]) begin
                    w_cnt_nxt[r] = r_cnt[r] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                r_cnt[r] <= '0;
            end
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                r_cnt[r] <= w_cnt_nxt[r];
            end
            r_ovf <= r_ovf | w_ovf_set;
            r_unf <= r_unf | w_unf_set;
        end
    end

    // A lone producer retiring this cycle is served by the bypass, so no stall.
    always_comb begin
        w_busy = '0;
        for (int p = 0; p < NREAD; p++) begin
            w_busy[p] = (r_cnt[ra[p*ADDR_W +: ADDR_W]] > CNT_W'(1)) ||
                        ((r_cnt[ra[p*ADDR_W +: ADDR_W]] == CNT_W'(1)) &&
                         !(we && (wa == ra[p*ADDR_W +: ADDR_W])));
        end
    end

    assign rd_busy      = w_busy;
    assign sb_overflow  = r_ovf;
    assign sb_underflow = r_unf;
endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with combinational write-to-read bypass and
// an attached pending-write scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned NREAD    = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter int unsigned CNT_W    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       wa,
    input  logic [DATA_W-1:0]       wd,
    input  logic [NREAD*ADDR_W-1:0] ra,
    output logic [NREAD*DATA_W-1:0] rd,
    output logic [NREAD-1:0]        rd_busy,
    input  logic                    iss_valid,
    input  logic [ADDR_W-1:0]       iss_dst,
    output logic                    sb_overflow,
    output logic                    sb_underflow
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]       r_rf [DEPTH];
    logic [NREAD*DATA_W-1:0] w_rd;
    logic                    w_wr_zero;

    assign w_wr_zero = ZERO_REG && (wa == ADDR_W'(REG_ZERO));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rf[i] <= '0;
            end
        end else if (we && !w_wr_zero) begin
            r_rf[wa] <= wd;
        end
    end

    always_comb begin
        w_rd = '0;
        for (int p = 0; p < NREAD; p++) begin
            if (ZERO_REG && (ra[p*ADDR_W +: ADDR_W] == ADDR_W'(REG_ZERO))) begin
                w_rd[p*DATA_W +: DATA_W] = '0;
            end else if (we && (wa == ra[p*ADDR_W +: ADDR_W])) begin
                w_rd[p*DATA_W +: DATA_W] = wd;
            end else begin
                w_rd[p*DATA_W +: DATA_W] = r_rf[ra[p*ADDR_W +: ADDR_W]];
            end
        end
    end

    assign rd = w_rd;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NREAD    (NREAD),
        .ZERO_REG (ZERO_REG),
        .CNT_W    (CNT_W)
    ) u_sb (
        .clk          (clk),
        .reset        (reset),
        .we           (we),
        .wa           (wa),
        .iss_valid    (iss_valid),
        .iss_dst      (iss_dst),
        .ra           (ra),
        .rd_busy      (rd_busy),
        .sb_overflow  (sb_overflow),
        .sb_underflow (sb_underflow)
    );
endmodule
